// File: rtl/stall_ctrl_v2_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state codes,
// stage indices, halt-code constants and a small width helper.
package stall_ctrl_v2_pkg;

    // Controller FSM: idle (no owner) or locked to one stall source.
    typedef enum logic {
        CtrlIdle = 1'b0,
        CtrlLock = 1'b1
    } ctrl_state_e;

    // Stage indices into the stall/flush vectors.
    localparam int unsigned StgIf  = 0;
    localparam int unsigned StgId  = 1;
    localparam int unsigned StgEx  = 2;
    localparam int unsigned StgMem = 3;
    localparam int unsigned StgWb  = 4;

    // Halt code reported when no source owns the pipeline.
    localparam int unsigned HaltNone = 0;

    // Level of rst that resets the core.
    localparam logic RstEnable = 1'b1;

    // Flush length is bounded to 1..15, so a 4-bit down-counter suffices.
    localparam int unsigned FlushCntW = 4;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int unsigned min_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stall_ctrl_v2_prio_arb.sv
// Combinational fixed-priority arbiter: bit 0 wins, reports found flag and
// the binary index of the lowest set request.
module stall_ctrl_v2_prio_arb #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req,
    output logic            found,
    output logic [IdxW-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/stall_ctrl_v2.sv
// Pipeline stall/flush controller. Arbitrates level-sensitive stall requests
// by fixed priority with ownership locking, drives per-stage stall and flush
// vectors, a halt code, a saturating stall-cycle counter and a sticky
// hang-detect flag. rdy=0 freezes all state and forces a full stall.
module stall_ctrl_v2
    import stall_ctrl_v2_pkg::*;
#(
    parameter int unsigned                 NUM_SRC    = 3,
    parameter int unsigned                 STAGES     = 5,
    parameter logic [NUM_SRC*STAGES-1:0]   SRC_MASK   = 15'b01111_01111_00001,
    parameter logic [STAGES-1:0]           FLUSH_MASK = 5'b00011,
    parameter int unsigned                 FLUSH_LEN  = 1,
    parameter int unsigned                 CNT_W      = 32,
    parameter int unsigned                 TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic [NUM_SRC-1:0]           req,
    input  logic                         flush_req,
    input  logic                         perf_clr,
    output logic [STAGES-1:0]            stall,
    output logic [STAGES-1:0]            flush,
    output logic [$clog2(NUM_SRC+1)-1:0] halt_code,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic                         timeout
);

    localparam int unsigned IdxW  = min_width(NUM_SRC - 1);
    localparam int unsigned HaltW = $clog2(NUM_SRC + 1);
    localparam int unsigned HoldW = min_width(TIMEOUT);

    ctrl_state_e          state_q, state_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic                 found_init, found_re;
    logic [IdxW-1:0]      idx_init, idx_re;
    logic [NUM_SRC-1:0]   req_excl;

    logic                 own_active;
    logic [IdxW-1:0]      own_idx;
    logic [STAGES-1:0]    own_mask;
    logic [HaltW-1:0]     halt_now;
    logic                 flush_active;
    logic [HoldW:0]       hold_inc;

    // Requests other than the current owner, for same-cycle re-arbitration.
    always_comb begin
        req_excl = req & ~(NUM_SRC'(1) << owner_q);
    end

    stall_ctrl_v2_prio_arb #(
        .N    (NUM_SRC),
        .IdxW (IdxW)
    ) u_arb_init (
        .req   (req),
        .found (found_init),
        .idx   (idx_init)
    );

    stall_ctrl_v2_prio_arb #(
        .N    (NUM_SRC),
        .IdxW (IdxW)
    ) u_arb_re (
        .req   (req_excl),
        .found (found_re),
        .idx   (idx_re)
    );

    // Ownership FSM next state, hold counter and hang detection.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_d     = hold_q;
        timeout_d  = timeout_q;
        own_active = 1'b0;
        own_idx    = owner_q;
        hold_inc   = {1'b0, hold_q} + (HoldW + 1)'(1);

        unique case (state_q)
            CtrlIdle: begin
                hold_d = '0;
                if (found_init) begin
                    own_active = 1'b1;
                    own_idx    = idx_init;
                    owner_d    = idx_init;
                    state_d    = CtrlLock;
                end
            end
            CtrlLock: begin
                if (req[owner_q]) begin
                    // Owner keeps the pipeline; higher-priority requests wait.
                    own_active = 1'b1;
                    if (TIMEOUT != 0) begin
                        if (hold_inc >= (HoldW + 1)'(TIMEOUT)) begin
                            hold_d    = HoldW'(TIMEOUT);
                            timeout_d = 1'b1;
                        end else begin
                            hold_d = hold_inc[HoldW-1:0];
                        end
                    end
                end else if (found_re) begin
                    // Gapless hand-over to the next waiting source.
                    own_active = 1'b1;
                    own_idx    = idx_re;
                    owner_d    = idx_re;
                    hold_d     = '0;
                end else begin
                    state_d = CtrlIdle;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = CtrlIdle;
                hold_d  = '0;
            end
        endcase
    end

    // Stage mask of the current owner and the matching halt code.
    always_comb begin
        own_mask = '0;
        halt_now = HaltW'(HaltNone);
        if (own_active) begin
            own_mask = SRC_MASK[int'(own_idx) * STAGES +: STAGES];
            halt_now = HaltW'(own_idx) + HaltW'(1);
        end
    end

    // Flush window: asserted on the request cycle, then while the count runs.
    always_comb begin
        flush_active = flush_req || (flush_cnt_q != '0);
        flush_cnt_d  = flush_cnt_q;
        if (flush_req) begin
            flush_cnt_d = FlushCntW'(FLUSH_LEN - 1);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - FlushCntW'(1);
        end
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (perf_clr) begin
            cnt_d = '0;
        end else if ((halt_now != HaltW'(HaltNone)) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output drive: reset silences, rdy=0 stalls everything, else flush wins.
    always_comb begin
        stall     = '0;
        flush     = '0;
        halt_code = HaltW'(HaltNone);
        if (rst == RstEnable) begin
            stall     = '0;
            flush     = '0;
            halt_code = HaltW'(HaltNone);
        end else if (!rdy) begin
            stall     = '1;
            flush     = '0;
            // Frozen state reflects the last halt code driven.
            halt_code = (state_q == CtrlLock) ? HaltW'(owner_q) + HaltW'(1)
                                              : HaltW'(HaltNone);
        end else begin
            flush     = flush_active ? FLUSH_MASK : '0;
            stall     = own_mask & ~flush;
            halt_code = halt_now;
        end
    end

    assign stall_cycles = cnt_q;
    assign timeout      = timeout_q;

    // State registers: synchronous reset, frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= CtrlIdle;
            owner_q     <= '0;
            flush_cnt_q <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            flush_cnt_q <= flush_cnt_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_stall_ctrl_v2.sv
// Directed bench for stall_ctrl_v2 (CNT_W=4, TIMEOUT=8). Each step drives one
// cycle of inputs, pushes the expected outputs, and compares them mid-cycle.
module tb_stall_ctrl_v2;

    logic       clk;
    logic       rst;
    logic       rdy;
    logic [2:0] req;
    logic       flush_req;
    logic       perf_clr;
    logic [4:0] stall;
    logic [4:0] flush;
    logic [1:0] halt_code;
    logic [3:0] stall_cycles;
    logic       timeout;

    int n_total;
    int n_pass;
    int exp_cnt;

    typedef struct {
        logic [4:0] stall;
        logic [4:0] flush;
        logic [1:0] halt;
        logic [3:0] cnt;
        logic [1:0] to;     // 0/1 expected, 3 = not compared
        string      tag;
    } exp_t;

    exp_t sb[$];

    stall_ctrl_v2 #(
        .NUM_SRC    (3),
        .STAGES     (5),
        .SRC_MASK   (15'b01111_01111_00001),
        .FLUSH_MASK (5'b00011),
        .FLUSH_LEN  (1),
        .CNT_W      (4),
        .TIMEOUT    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .req          (req),
        .flush_req    (flush_req),
        .perf_clr     (perf_clr),
        .stall        (stall),
        .flush        (flush),
        .halt_code    (halt_code),
        .stall_cycles (stall_cycles),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive, push expectation, compare at negedge, advance.
    task automatic step(input string tag, input logic r, input logic rd,
                        input logic [2:0] rq, input logic fr, input logic pc,
                        input logic [4:0] es, input logic [4:0] ef,
                        input logic [1:0] eh, input logic [1:0] eto);
        exp_t e;
        rst       = r;
        rdy       = rd;
        req       = rq;
        flush_req = fr;
        perf_clr  = pc;
        e.stall = es;
        e.flush = ef;
        e.halt  = eh;
        e.cnt   = 4'(exp_cnt);
        e.to    = eto;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, "_stall"}, {27'b0, stall}, {27'b0, e.stall});
        chk({e.tag, "_flush"}, {27'b0, flush}, {27'b0, e.flush});
        chk({e.tag, "_halt"}, {30'b0, halt_code}, {30'b0, e.halt});
        chk({e.tag, "_cycles"}, {28'b0, stall_cycles}, {28'b0, e.cnt});
        if (e.to != 2'd3) chk({e.tag, "_timeout"}, {31'b0, timeout}, {30'b0, e.to});
        // Reference model of the perf counter, applied at the coming edge.
        if (r) exp_cnt = 0;
        else if (rd) begin
            if (pc) exp_cnt = 0;
            else if (eh != 2'd0 && exp_cnt < 15) exp_cnt = exp_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        rdy       = 1'b1;
        req       = 3'b000;
        flush_req = 1'b0;
        perf_clr  = 1'b0;
        @(posedge clk);
        #1;

        // Reset dominates requests and flush.
        step("rst_a", 1, 1, 3'b111, 1, 0, 5'b00000, 5'b00000, 2'd0, 2'd0);
        step("rst_b", 1, 1, 3'b111, 1, 0, 5'b00000, 5'b00000, 2'd0, 2'd0);
        step("first_grant", 0, 1, 3'b010, 0, 0, 5'b01111, 5'b00000, 2'd2, 2'd0);
        step("lock1", 0, 1, 3'b010, 0, 0, 5'b01111, 5'b00000, 2'd2, 2'd0);

        // Flush over stall, one-cycle flush length.
        step("flush", 0, 1, 3'b010, 1, 0, 5'b01100, 5'b00011, 2'd2, 2'd0);
        step("post_flush", 0, 1, 3'b010, 0, 0, 5'b01111, 5'b00000, 2'd2, 2'd0);
        step("release", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd0);

        // No preemption, then gapless hand-over.
        for (int i = 0; i < 3; i++)
            step("np_own2", 0, 1, 3'b100, 0, 0, 5'b01111, 5'b00000, 2'd3, 2'd0);
        for (int i = 0; i < 2; i++)
            step("np_hold", 0, 1, 3'b101, 0, 0, 5'b01111, 5'b00000, 2'd3, 2'd0);
        step("handover", 0, 1, 3'b001, 0, 0, 5'b00001, 5'b00000, 2'd1, 2'd0);
        step("release2", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd0);

        // rdy freeze while owner 0 is locked.
        step("frz_grant", 0, 1, 3'b001, 0, 0, 5'b00001, 5'b00000, 2'd1, 2'd0);
        step("frz_lock", 0, 1, 3'b001, 0, 0, 5'b00001, 5'b00000, 2'd1, 2'd0);
        step("frz_0", 0, 0, 3'b000, 1, 0, 5'b11111, 5'b00000, 2'd1, 2'd0);
        step("frz_1", 0, 0, 3'b110, 0, 0, 5'b11111, 5'b00000, 2'd1, 2'd0);
        step("frz_2", 0, 0, 3'b010, 0, 1, 5'b11111, 5'b00000, 2'd1, 2'd0);
        step("frz_3", 0, 0, 3'b111, 0, 0, 5'b11111, 5'b00000, 2'd1, 2'd0);
        step("frz_resume", 0, 1, 3'b001, 0, 0, 5'b00001, 5'b00000, 2'd1, 2'd0);
        step("frz_rel", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd0);

        // Hang detection with TIMEOUT=8.
        step("to_rst", 1, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd0);
        step("to_grant", 0, 1, 3'b001, 0, 0, 5'b00001, 5'b00000, 2'd1, 2'd0);
        for (int i = 0; i < 7; i++)
            step("to_lock", 0, 1, 3'b001, 0, 0, 5'b00001, 5'b00000, 2'd1, 2'd0);
        step("to_lock8", 0, 1, 3'b001, 0, 0, 5'b00001, 5'b00000, 2'd1, 2'd3);
        step("to_set", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd1);
        step("to_sticky", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd1);
        step("to_clr_rst", 1, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd3);
        step("to_cleared", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd0);

        // Perf counter: 10 stalled cycles, clear, then saturation at 15.
        for (int i = 0; i < 10; i++)
            step("perf_run", 0, 1, 3'b010, 0, 0, 5'b01111, 5'b00000, 2'd2, 2'd3);
        chk("perf_ten", {28'b0, stall_cycles}, 32'd10);
        step("perf_clr", 0, 1, 3'b010, 0, 1, 5'b01111, 5'b00000, 2'd2, 2'd1);
        chk("perf_cleared", {28'b0, stall_cycles}, 32'd0);
        for (int i = 0; i < 20; i++)
            step("perf_sat", 0, 1, 3'b010, 0, 0, 5'b01111, 5'b00000, 2'd2, 2'd1);
        step("perf_end", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 2'd0, 2'd1);
        chk("perf_saturated", {28'b0, stall_cycles}, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stall_ctrl_v2.md
Name: stall_ctrl_v2

Overview:
- Parametrised pipeline stall/flush controller for the RISC-V core.
- Arbitrates NUM_SRC stall requests (IF fetch, MEM access, IO out, ...) by fixed priority, with ownership locking.
- Drives per-stage stall and flush vectors, a compact halt code, a stall-cycle perf counter and a hang-detect timeout flag.
- Sits between the memory/IO request units and every pipeline-register stage.

Parameters:
- NUM_SRC, 3: number of stall request sources; bit 0 has the highest priority.
- STAGES, 5: pipeline stages; bit 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
- SRC_MASK, 15'b01111_01111_00001: flat NUM_SRC*STAGES vector; slice i gives the stages stalled for source i.
- FLUSH_MASK, 5'b00011: stages flushed on flush_req.
- FLUSH_LEN, 1: cycles flush stays asserted, range 1..15.
- CNT_W, 32: perf counter width.
- TIMEOUT, 1024: max cycles one owner may hold; 0 disables the check.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rdy  in  1  chip ready; low freezes the controller.
- req  in  NUM_SRC  stall requests, level-sensitive.
- flush_req  in  1  redirect request (branch/jump mispredict).
- perf_clr  in  1  clears stall_cycles.
- stall  out  STAGES  per-stage hold.
- flush  out  STAGES  per-stage bubble insert.
- halt_code  out  $clog2(NUM_SRC+1)  0 = none, else owner index+1.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.
- timeout  out  1  sticky hang flag.

Behaviour:
- Reset: rst is synchronous and active-high.
  - While rst=1: stall=0, flush=0, halt_code=0.
  - Registers cleared: state=IDLE, owner=0, flush count=0, hold count=0, stall_cycles=0, timeout=0.
  - Reset mid-stall or mid-flush aborts immediately.
- FSM states: IDLE, LOCK. Flush is tracked by an independent down-counter flush_cnt.
- IDLE:
  - If req!=0, winner g = lowest set index.
  - stall = SRC_MASK[g] in the same cycle (0-cycle latency).
  - owner<=g; next state LOCK.
- LOCK:
  - While req[owner]=1: stall = SRC_MASK[owner]. No preemption, even by a higher-priority request.
  - When req[owner]=0: re-arbitrate combinationally in that same cycle over the remaining req bits.
    - Winner found: stall = its mask, owner<=winner, stay in LOCK, hold count restarts.
    - No winner: stall=0, next state IDLE.
- Flush:
  - flush_req=1 sets flush=FLUSH_MASK in the same cycle and loads flush_cnt<=FLUSH_LEN-1.
  - flush stays asserted while flush_cnt!=0, decrementing each cycle.
  - flush_req during an active flush reloads the count.
- Stall/flush overlap: flush wins per stage. Final stall = mask & ~flush. Stall ownership is unaffected by flush.
- halt_code = owner+1 whenever any stall bit is driven by ownership (including the arbitration cycle), else 0.
- rdy=0:
  - stall = all ones, flush=0, halt_code unchanged.
  - All registers hold; flush_cnt, counters and FSM are frozen.
  - Requests are not sampled.
- stall_cycles:
  - +1 on each rdy=1 cycle with halt_code!=0.
  - Saturates at all ones.
  - perf_clr has priority over increment: value becomes 0 that cycle.
- timeout:
  - Hold counter (width $clog2(TIMEOUT+1)) increments each LOCK cycle and resets on owner change or on return to IDLE.
  - Reaching TIMEOUT sets timeout=1, which stays set until rst.
  - No counting when TIMEOUT=0.
- Simultaneous request rise and fall: a request released and a new request raised in the same cycle hand over without a gap cycle.

Decomposition:
- define.v gains:
  - the FSM state codes `CtrlIdle/`CtrlLock;
  - stage-index constants `StgIF..`StgWB;
  - halt-code constant `HaltNone=0 (alongside the existing `RstEnable).
- One sub-module, prio_arb: combinational fixed-priority arbiter.
  - Inputs: NUM_SRC request bits.
  - Outputs: found flag plus binary index.
  - Instantiated twice: initial grant, and re-arbitration excluding the current owner.

Test Plan:
- Reset: hold rst=1 with req=3'b111 and flush_req=1 -> stall=0, flush=0, halt_code=0. First cycle after release with req=3'b010 -> stall=5'b01111, halt_code=2.
- No preemption: req=3'b100 for 3 cycles, then req=3'b101 -> stall=5'b01111 and halt_code=3 until req[2] drops. Next cycle halt_code=1, stall=5'b00001, no gap cycle.
- Flush over stall: owner 1 locked (stall=5'b01111), pulse flush_req -> that cycle flush=5'b00011, stall=5'b01100. Next cycle (FLUSH_LEN=1) flush=0, stall=5'b01111.
- rdy freeze: lock owner 0, drop rdy for 4 cycles while toggling req -> stall=5'b11111, stall_cycles constant. On rdy=1, owner 0 is still held.
- Timeout: TIMEOUT=8, hold req=3'b001 for 8 LOCK cycles -> timeout=1 from that cycle on. Dropping req does not clear it; only rst does.
- Perf: 10 stalled cycles -> stall_cycles=10. perf_clr concurrent with a stalled cycle -> 0. With CNT_W=4, 20 stalled cycles -> 15 (saturated).
